// File: rtl/dm_responder.sv
// Data-memory responder: req/ready slave with programmable wait states in front of a word-addressed RAM.
// Optional build macro DM_SIGNEXT_EN: byte loads sign-extend instead of zero-extend.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        MemByte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = IDX_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                byte_q, byte_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         ready_unused_guard_c;
    logic                addr_unused_c;
    logic                ready_d, err_d;
    logic                ready_q, err_q;
    logic [31:0]         rdata_d, rdata_q;

    logic [IDX_W-1:0]    idx_c;
    logic [1:0]          lane_c;
    logic                misalign_c;
    logic [31:0]         rd_word_c;
    logic [7:0]          rd_byte_c;
    logic [31:0]         load_val_c;
    logic [3:0]          mem_be_c;
    logic [31:0]         mem_wdata_c;

    logic [31:0]         mem [DEPTH_WORDS];

    // Address bits above the RAM window are deliberately ignored (modulo wrap).
    assign addr_unused_c        = ^addr[31:ADDR_W];
    assign ready_unused_guard_c = '0;

    // State and request-capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state: accept in IDLE, count down wait states, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr[ADDR_W-1:0];
                    we_d    = we;
                    byte_d  = MemByte;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign idx_c      = addr_q[ADDR_W-1:2];
    assign lane_c     = addr_q[1:0];
    assign misalign_c = !byte_q && (lane_c != 2'd0);
    assign rd_word_c  = mem[idx_c];

    // Output/RAM-control decode for the RESP cycle.
    always_comb begin
        ready_d     = 1'b0;
        err_d       = 1'b0;
        rdata_d     = ready_unused_guard_c;
        mem_be_c    = 4'b0000;
        mem_wdata_c = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        case (lane_c)
            2'd0:    rd_byte_c = rd_word_c[7:0];
            2'd1:    rd_byte_c = rd_word_c[15:8];
            2'd2:    rd_byte_c = rd_word_c[23:16];
            default: rd_byte_c = rd_word_c[31:24];
        endcase
`ifdef DM_SIGNEXT_EN
        load_val_c = byte_q ? {{24{rd_byte_c[7]}}, rd_byte_c} : rd_word_c;
`else
        load_val_c = byte_q ? {24'b0, rd_byte_c} : rd_word_c;
`endif
        if (state_q == S_RESP) begin
            ready_d = 1'b1;
            err_d   = misalign_c;
            if (!misalign_c) begin
                if (we_q) mem_be_c = byte_q ? (4'b0001 << lane_c) : 4'b1111;
                else      rdata_d  = load_val_c;
            end
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is never cleared; a reset in the RESP cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_c[b]) mem[idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed table-driven bench for dm_responder: one WAIT_CYCLES=2 instance, one WAIT_CYCLES=0 instance.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, mb0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0;
    logic        req1, we1, mb1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1, err1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .IDX_W(10), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .MemByte(mb0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0));

    dm_responder #(.DEPTH_WORDS(1024), .IDX_W(10), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .MemByte(mb1), .addr(addr1),
        .wdata(wdata1), .rdata(rdata1), .ready(ready1), .err(err1));

    typedef struct {
        logic        we;
        logic        mb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on u0: returns response and the number of edges from acceptance to ready.
    task automatic txn(input logic w, input logic m, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req0 = 1'b1; we0 = w; mb0 = m; addr0 = a; wdata0 = d;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0; mb0 = 1'b0; addr0 = '0; wdata0 = '0;
        lat = 99; rd = 32'hx; e = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            @(posedge clk); #1;
            if (ready0) begin
                lat = k; rd = rdata0; e = err0;
                break;
            end
        end
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(ready0), 32'd0);
    endtask

    vec_t        vecs [16];
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          nready;
    logic [31:0] cap;
    logic        rdy_seen [6];
    logic [31:0] b2b_rd;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h20, 32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h22, 32'h123456AA, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h11AA3344, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h23, 32'h0,        32'h00000011, 1'b0};
`ifdef DM_SIGNEXT_EN
        vecs[6]  = '{1'b0, 1'b1, 32'h22, 32'h0,        32'hFFFFFFAA, 1'b0};
`else
        vecs[6]  = '{1'b0, 1'b1, 32'h22, 32'h0,        32'h000000AA, 1'b0};
`endif
        vecs[7]  = '{1'b0, 1'b1, 32'h20, 32'h0,        32'h00000044, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h30, 32'h0BADF00D, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h31, 32'h12345678, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'h0BADF00D, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h32, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'h33, 32'h00000080, 32'h0,        1'b0};
`ifdef DM_SIGNEXT_EN
        vecs[13] = '{1'b0, 1'b1, 32'h33, 32'h0,        32'hFFFFFF80, 1'b0};
`else
        vecs[13] = '{1'b0, 1'b1, 32'h33, 32'h0,        32'h00000080, 1'b0};
`endif
        vecs[14] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'h80ADF00D, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h40, 32'h11110000, 32'h0,        1'b0};

        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; mb0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; mb1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready0), 32'd0);
        check("reset_err",   32'(err0),   32'd0);
        check("reset_rdata", rdata0,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            txn(vecs[i].we, vecs[i].mb, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_rdata", i),   rd,        vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i),     32'(e),    32'(vecs[i].exp_err));
        end

        // Reset during WAIT of a store aborts it.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; mb0 = 1'b0; addr0 = 32'h40; wdata0 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nready = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready0) nready++;
        end
        check("reset_abort_no_ready", 32'(nready), 32'd0);
        txn(1'b0, 1'b0, 32'h40, 32'h0, rd, e, lat);
        check("reset_abort_latency", 32'(lat), 32'd3);
        check("reset_abort_old_data", rd, 32'h11110000);

        // req and address toggled during WAIT are ignored.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; mb0 = 1'b0; addr0 = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h0;
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h24;
        nready = 0; cap = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready0) begin
                nready++;
                cap = rdata0;
            end
        end
        check("ignored_req_ready_count", 32'(nready), 32'd1);
        check("ignored_req_rdata", cap, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat);
        check("ignored_req_no_write", rd, 32'h11AA3344);

        // WAIT_CYCLES=0: address wrap and back-to-back with req held high.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; mb1 = 1'b0; addr1 = 32'h1004; wdata1 = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        we1 = 1'b0; addr1 = 32'h4; wdata1 = 32'h0;
        b2b_rd = '0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            rdy_seen[k] = ready1;
            if (k == 1) check("b2b_store_rdata", rdata1, 32'h0);
            if (k == 3) b2b_rd = rdata1;
            @(negedge clk);
            if (k == 2) req1 = 1'b0;
        end
        check("b2b_ready_e1", 32'(rdy_seen[1]), 32'd1);
        check("b2b_ready_e2", 32'(rdy_seen[2]), 32'd0);
        check("b2b_ready_e3", 32'(rdy_seen[3]), 32'd1);
        check("b2b_ready_e4", 32'(rdy_seen[4]), 32'd0);
        check("b2b_ready_e5", 32'(rdy_seen[5]), 32'd0);
        check("b2b_wrap_rdata", b2b_rd, 32'h5A5A5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
